serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor sequencer. Computes A-B by time-sharing one full-subtractor cell, built from two halfsub instances, across all bit positions, LSB first, one bit per clock. Start/busy/done handshake toward the host. Intended as the controller that drives the existing halfsub datapath for multi-bit operands in area-constrained paths.

---
 rtl/serial_sub_ctrl_pkg.sv | 11 +
 rtl/halfsub.sv | 13 +
 rtl/serial_fullsub_cell.sv | 18 +
 rtl/serial_sub_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
// Pure declarations; no logic, no latency, no flow control.
package serial_sub_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/halfsub.sv
// One-bit half subtractor: d = a - b, bor set when b > a.
// Combinational, zero latency, no flow control.
module halfsub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bor
);

  assign d   = a ^ b;
  assign bor = ~a & b;

endmodule

// File: rtl/serial_fullsub_cell.sv
// Full subtractor built from two half subtractors; the single shared datapath cell.
// Combinational, zero latency, no flow control.
module serial_fullsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1, b1, b2;

  halfsub u_hs1 (.a(a),  .b(b),   .d(d1), .bor(b1));
  halfsub u_hs2 (.a(d1), .b(bin), .d(d),  .bor(b2));

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B sequencer, LSB first; done pulses W+1 cycles after start is accepted,
// start is ignored while busy. Optional signed-overflow output under SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter  int W  = DEFAULT_W,
  localparam int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bor
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [W-1:0]  res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          brw_q, brw_d, bor_q, bor_d, done_q, done_d;
  logic          cell_d, cell_bout, last_bit;

  serial_fullsub_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CW'(W - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_msb_q, ovf_msb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bor_d   = bor_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_msb_d = ovf_msb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result fills from the MSB side so bit 0 lands at position 0 after W shifts.
        res_d  = {cell_d, res_q[W-1:1]};
        brw_d  = cell_bout;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        if (last_bit) begin
          state_d = ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_msb_d = (a_sr_q[0] ^ b_sr_q[0]) & (a_sr_q[0] ^ cell_d);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        diff_d  = res_q;
        bor_d   = brw_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d = ovf_msb_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bor_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_msb_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bor_q   <= bor_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_msb_q <= ovf_msb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = done_q;
  assign diff = diff_q;
  assign bor  = bor_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at W=8 and W=2; ovf checks only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       busy, done, bor;
  logic [7:0] diff;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bor2;
  logic [1:0] diff2;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf, ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .bor(bor)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_sub_ctrl #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .diff(diff2), .bor(bor2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one W=8 op and wait (bounded) for done; returns cycles from accept edge to done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busy_n);
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_err++; $display("FAIL reset_diff: got %h want 00", diff); end
    n_cmp++; if (bor !== 1'b0) begin n_err++; $display("FAIL reset_bor: got %b want 0", bor); end
    n_cmp++; if (busy2 !== 1'b0 || diff2 !== 2'b00) begin n_err++; $display("FAIL reset_w2: got busy %b diff %b want 0 00", busy2, diff2); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, busy_n;
    do_op(8'd100, 8'd37, lat, busy_n);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++; if (busy_n !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_n); end
    n_cmp++; if (diff !== 8'd63) begin n_err++; $display("FAIL basic_diff: got %0d want 63", diff); end
    n_cmp++; if (bor !== 1'b0) begin n_err++; $display("FAIL basic_bor: got %b want 0", bor); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done); end
    n_cmp++; if (diff !== 8'd63) begin n_err++; $display("FAIL diff_hold: got %0d want 63", diff); end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3] = '{8'd5, 8'd0, 8'hFF};
    logic [7:0] vb [3] = '{8'd9, 8'd0, 8'hFF};
    logic [7:0] vd [3] = '{8'hFC, 8'h00, 8'h00};
    logic       vr [3] = '{1'b1, 1'b0, 1'b0};
    int lat, busy_n;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], lat, busy_n);
      n_cmp++; if (diff !== vd[i] || bor !== vr[i] || lat !== 9)
        begin n_err++; $display("FAIL vec%0d: got diff %h bor %b lat %0d want %h %b 9", i, diff, bor, lat, vd[i], vr[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat, dones;
    a_in = 8'd100; b_in = 8'd37; start = 1'b1;
    tick();
    a_in = 8'hAA; b_in = 8'h11;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    n_cmp++; if (lat !== 9 || diff !== 8'd63 || bor !== 1'b0)
      begin n_err++; $display("FAIL b2b_op1: got lat %0d diff %0d bor %b want 9 63 0", lat, diff, bor); end
    a_in = 8'd5; b_in = 8'd9;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_after_done: got busy %b want 1", busy); end
    a_in = 8'h33; b_in = 8'h01;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    n_cmp++; if (lat !== 9 || diff !== 8'hFC || bor !== 1'b1)
      begin n_err++; $display("FAIL b2b_op2: got lat %0d diff %h bor %b want 9 fc 1", lat, diff, bor); end
    dones = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done) dones++; end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL b2b_extra_done: got %0d want 0", dones); end
  endtask

  task automatic test_reset_mid_run();
    int dones, lat, busy_n;
    a_in = 8'd5; b_in = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_state: got busy %b done %b want 0 0", busy, done); end
    n_cmp++; if (diff !== 8'h00 || bor !== 1'b0) begin n_err++; $display("FAIL midrst_result: got diff %h bor %b want 00 0", diff, bor); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done) dones++; end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
    do_op(8'd100, 8'd37, lat, busy_n);
    n_cmp++; if (lat !== 9 || diff !== 8'd63 || bor !== 1'b0)
      begin n_err++; $display("FAIL midrst_recover: got lat %0d diff %0d bor %b want 9 63 0", lat, diff, bor); end
    tick();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat, busy_n;
    do_op(8'h80, 8'h01, lat, busy_n);
    n_cmp++; if (diff !== 8'h7F || bor !== 1'b0 || ovf !== 1'b1)
      begin n_err++; $display("FAIL ovf_set: got diff %h bor %b ovf %b want 7f 0 1", diff, bor, ovf); end
    tick();
    do_op(8'h10, 8'h20, lat, busy_n);
    n_cmp++; if (diff !== 8'hF0 || bor !== 1'b1 || ovf !== 1'b0)
      begin n_err++; $display("FAIL ovf_clear: got diff %h bor %b ovf %b want f0 1 0", diff, bor, ovf); end
    tick();
  endtask
`endif

  task automatic test_w2();
    int lat;
    a2 = 2'b01; b2 = 2'b10; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL w2_latency: got %0d want 3", lat); end
    n_cmp++; if (diff2 !== 2'b11 || bor2 !== 1'b1)
      begin n_err++; $display("FAIL w2_result: got diff %b bor %b want 11 1", diff2, bor2); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_w2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
